// File: rtl/regfile_wb_if.sv
// Bus bundle for regfile_wb: write-back port, two ID read ports, issue port
// and the pending-write count. master = pipeline side, slave = register file.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              busy1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              busy2;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_wd;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, re1, raddr1, re2, raddr2, iss_en, iss_wd,
    input  rdata1, busy1, rdata2, busy2, pend_cnt
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, re1, raddr1, re2, raddr2, iss_en, iss_wd,
    output rdata1, busy1, rdata2, busy2, pend_cnt
  );
endinterface

// File: rtl/regfile_wb.sv
// Architectural register file with write-back port, two combinational read
// ports and a pending-write scoreboard. Define REGFILE_BYPASS_EN for forwarding.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave bus
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_hit;
  logic              fwd1;
  logic              fwd2;

  assign wr_hit = bus.wb_wreg && (bus.wb_wd != '0);

  // The issue set is applied after the write-back clear so a same-address
  // collision leaves the bit owned by the newer instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[bus.wb_wd] = 1'b0;
    if (bus.iss_en && (bus.iss_wd != '0))
      busy_nxt[bus.iss_wd] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is reset because an asynchronous clear of every register is architecturally required; this keeps it in flops rather than RAM.
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (wr_hit)
        regs[bus.wb_wd] <= bus.wb_wdata;
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = bus.re1 && (bus.raddr1 != '0) && wr_hit && (bus.wb_wd == bus.raddr1);
  assign fwd2 = bus.re2 && (bus.raddr2 != '0) && wr_hit && (bus.wb_wd == bus.raddr2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Reads are forced to zero while reset is held, even if write-back is active.
  assign bus.rdata1 = (!rst || !bus.re1 || (bus.raddr1 == '0)) ? '0 :
                      fwd1 ? bus.wb_wdata : regs[bus.raddr1];
  assign bus.rdata2 = (!rst || !bus.re2 || (bus.raddr2 == '0)) ? '0 :
                      fwd2 ? bus.wb_wdata : regs[bus.raddr2];

  assign bus.busy1 = rst && bus.re1 && busy[bus.raddr1] && !fwd1;
  assign bus.busy2 = rst && bus.re2 && busy[bus.raddr2] && !fwd2;

  assign bus.pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table, randomized run
// against a behavioural model, and an asynchronous mid-run reset sequence.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_wb #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain arrays updated by the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  typedef struct {
    logic        wreg;  logic [4:0] wd;  logic [31:0] wdata;
    logic        iss;   logic [4:0] iwd;
    logic        re1;   logic [4:0] ra1;
    logic        re2;   logic [4:0] ra2;
    logic [31:0] rd1;   logic [31:0] rd2;
    logic        b1;    logic       b2;  logic [5:0] cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] model_rd(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 32'd0;
    if (BYP && bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 1'b0;
    if (BYP && bus.wb_wreg && bus.wb_wd == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void model_edge();
    if (bus.wb_wreg && bus.wb_wd != 5'd0) begin
      m_regs[bus.wb_wd] = bus.wb_wdata;
      m_busy[bus.wb_wd] = 1'b0;
    end
    if (bus.iss_en && bus.iss_wd != 5'd0)
      m_busy[bus.iss_wd] = 1'b1;
  endfunction

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic iss, input logic [4:0] iwd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    bus.wb_wreg = wreg; bus.wb_wd = wd; bus.wb_wdata = wdata;
    bus.iss_en = iss;   bus.iss_wd = iwd;
    bus.re1 = re1; bus.raddr1 = ra1;
    bus.re2 = re2; bus.raddr2 = ra2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rdata1"}, 64'(bus.rdata1), 64'(model_rd(bus.re1, bus.raddr1)));
    check({tag, " rdata2"}, 64'(bus.rdata2), 64'(model_rd(bus.re2, bus.raddr2)));
    check({tag, " busy1"},  64'(bus.busy1),  64'(model_busy(bus.re1, bus.raddr1)));
    check({tag, " busy2"},  64'(bus.busy2),  64'(model_busy(bus.re2, bus.raddr2)));
    check({tag, " pend_cnt"}, 64'(bus.pend_cnt), 64'(model_cnt()));
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    // Directed table: inputs applied for one cycle, outputs checked before the edge.
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd0,
                 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0};
    vecs[2]  = '{1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5,
                 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0,
                 BYP ? 32'h22 : 32'h11, 32'h0, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0,
                 32'h22, 32'h0, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0,
                 32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd4,
                 32'h0, 32'h0, 1'b1, 1'b1, 6'd2};
    vecs[7]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0,
                 BYP ? 32'h33 : 32'h0, 32'h0, !BYP, 1'b0, 6'd2};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3, 1'b0, 5'd0,
                 32'h33, 32'h0, 1'b0, 1'b0, 6'd1};
    vecs[9]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd9,
                 32'h0, BYP ? 32'h99 : 32'h0, 1'b1, !BYP, 6'd2};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9,
                 32'h0, 32'h99, 1'b0, 1'b1, 6'd2};
    vecs[11] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0,
                 BYP ? 32'h44 : 32'h0, 32'h0, !BYP, 1'b0, 6'd2};
    vecs[12] = '{1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd5,
                 32'h44, BYP ? 32'h55 : 32'hDEADBEEF, 1'b0, 1'b0, 6'd1};
    vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5,
                 32'h0, 32'h55, 1'b0, 1'b0, 6'd1};

    model_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset held: every address reads zero even with write-back driven.
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), $urandom, 1'b1, 5'(a), 1'b1, 5'(a), 1'b1, 5'(31 - a));
      #3;
      check($sformatf("rst rdata1 a%0d", a), 64'(bus.rdata1), 64'd0);
      check($sformatf("rst rdata2 a%0d", a), 64'(bus.rdata2), 64'd0);
      check($sformatf("rst busy a%0d", a), 64'({bus.busy1, bus.busy2}), 64'd0);
      check($sformatf("rst pend_cnt a%0d", a), 64'(bus.pend_cnt), 64'd0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wreg, vecs[i].wd, vecs[i].wdata, vecs[i].iss, vecs[i].iwd,
            vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      @(negedge clk);
      check($sformatf("v%0d rdata1", i), 64'(bus.rdata1), 64'(vecs[i].rd1));
      check($sformatf("v%0d rdata2", i), 64'(bus.rdata2), 64'(vecs[i].rd2));
      check($sformatf("v%0d busy1", i), 64'(bus.busy1), 64'(vecs[i].b1));
      check($sformatf("v%0d busy2", i), 64'(bus.busy2), 64'(vecs[i].b2));
      check($sformatf("v%0d pend_cnt", i), 64'(bus.pend_cnt), 64'(vecs[i].cnt));
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
            1'($urandom_range(0, 1)), rnd_addr(),
            1'($urandom_range(0, 3) != 0), rnd_addr(),
            1'($urandom_range(0, 3) != 0), rnd_addr());
      @(negedge clk);
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    // Clean start, then r2/r6 busy with data before the mid-cycle reset.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    drive(1'b1, 5'd2, 32'hA2, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd6, 32'hA6, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 5'd6);
    @(negedge clk);
    check("pre rdata1", 64'(bus.rdata1), 64'hA2);
    check("pre rdata2", 64'(bus.rdata2), 64'hA6);
    check("pre busy", 64'({bus.busy1, bus.busy2}), 64'b11);
    check("pre pend_cnt", 64'(bus.pend_cnt), 64'd2);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async busy", 64'({bus.busy1, bus.busy2}), 64'b00);
    check("async pend_cnt", 64'(bus.pend_cnt), 64'd0);
    check("async rdata1", 64'(bus.rdata1), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("post rdata1", 64'(bus.rdata1), 64'd0);
    check("post rdata2", 64'(bus.rdata2), 64'd0);
    check("post busy", 64'({bus.busy1, bus.busy2}), 64'b00);
    check("post pend_cnt", 64'(bus.pend_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural general-purpose register file; the consuming end of the write-back path driven by the MEM/WB pipeline stage.
  - Accepts one write per cycle from write-back (address, enable, data).
  - Serves two combinational read ports to the ID stage.
- Keeps a per-register pending-write scoreboard so ID can detect RAW hazards on results not yet written back.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NREGS, 32, register count (2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- wb_wd  input  ADDR_W  write-back destination address.
- wb_wreg  input  1  write-back enable.
- wb_wdata  input  DATA_W  write-back data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data.
- busy1  output  1  register at raddr1 has a pending write.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data.
- busy2  output  1  register at raddr2 has a pending write.
- iss_en  input  1  ID issues an instruction that will write iss_wd.
- iss_wd  input  ADDR_W  destination of the issued instruction.
- pend_cnt  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (rst=0, asynchronous)
  - All registers cleared to 0.
  - All busy bits cleared; pend_cnt=0.
  - rdata1/rdata2 read 0 while reset is held.
  - A reset in mid-operation drops all pending marks immediately.
- Write
  - On posedge clk, if wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata.
  - Writes to address 0 are ignored.
- Read (combinational)
  - If reN=0: rdataN=0.
  - Else if raddrN=0: rdataN=0.
  - Else: rdataN=reg[raddrN], subject to the bypass rule under Optional Feature.
- Scoreboard, one busy bit per register; bit 0 is permanently 0.
  - Set: on posedge, iss_en=1 and iss_wd!=0 sets busy[iss_wd].
  - Clear: on posedge, wb_wreg=1 and wb_wd!=0 clears busy[wb_wd].
  - Set and clear to the same address in the same cycle: the set wins, because the newer instruction owns the register.
  - Set to an already-busy register: the bit stays 1. There is no nesting; the first write-back clears it.
  - Clear of a non-busy register: the data write still occurs and the bit stays 0.
- busyN
  - busyN = reN & busy[raddrN], evaluated combinationally on the current-cycle bits.
  - busyN is 0 when raddrN=0.
- pend_cnt
  - Registered population count of busy bits, updated in the same cycle as the bits.
  - Range 0..NREGS-1; it cannot overflow because bit 0 is never set.
- Latency
  - Write data is visible on a read port the cycle after the write-back edge without bypass, or in the same cycle with bypass.
  - Busy bits change one edge after iss_en / wb_wreg.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If reN=1, raddrN!=0, wb_wreg=1 and wb_wd==raddrN, then rdataN=wb_wdata (read-during-write forwarding).
  - busyN is also forced to 0 in that same case, since the value is forwarded.
- Undefined:
  - rdataN returns the old stored value during a same-cycle write.
  - busyN reflects the stored bit until the edge.

Test Plan:
- Reset: hold rst=0, then release.
  - -> rdata1=rdata2=0 for all addresses; busy1=busy2=0; pend_cnt=0.
- Write then read: write 0xDEADBEEF to r5 (wb_wreg=1, wb_wd=5), then next cycle re1=1, raddr1=5.
  - -> rdata1=0xDEADBEEF.
  - Write 0x1234 to r0 -> raddr2=0 reads 0.
- Bypass: r7=0x11; same cycle write 0x22 to r7 while raddr1=7.
  - -> rdata1=0x22 with REGFILE_BYPASS_EN defined, 0x11 without it.
  - Next cycle -> 0x22 in both builds.
- Scoreboard: iss_en for r3, then r4.
  - -> busy on raddr1=3 and raddr2=4; pend_cnt=2.
  - Write-back to r3 -> busy1=0, pend_cnt=1.
- Set/clear collision: r9 busy; in one cycle iss_wd=9 and wb_wd=9 with wb_wreg=1.
  - -> busy[9] remains 1, reg[9] updated, pend_cnt unchanged.
- Async reset mid-run: r2, r6 busy (pend_cnt=2), data written; drive rst=0 between clock edges.
  - -> busy bits, pend_cnt and all register contents clear immediately, without waiting for a clock edge.
